// File: rtl/mod_div_pkg.sv
// rtl/mod_div_pkg.sv - shared widths, state encoding and helpers for mod_div
package mod_div_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int PREM_W     = 5;
    localparam int ITER_N     = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Magnitude of a two's-complement value; -2^(W-1) maps to 2^(W-1),
    // which still fits the unsigned W-bit result.
    function automatic logic [DIVIDEND_W-1:0] abs_dividend(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] abs_divisor(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mod_div_step.sv
// rtl/mod_div_step.sv - one combinational restoring shift/subtract step
//
// Ports:
//   prem      - current partial remainder (always < dvs, so its MSB is 0)
//   bit_in    - next dividend bit shifted into the partial remainder
//   dvs       - unsigned divisor magnitude
//   prem_next - partial remainder after this step
//   q_bit     - quotient bit produced by this step
module mod_div_step
    import mod_div_pkg::*;
(
    input  logic [PREM_W-1:0]    prem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] dvs,
    output logic [PREM_W-1:0]    prem_next,
    output logic                 q_bit
);

    logic [PREM_W-1:0] shifted;
    logic [PREM_W-1:0] dvs_ext;
    logic [PREM_W-1:0] diff;

    always_comb begin
        shifted   = {prem[PREM_W-2:0], bit_in};
        dvs_ext   = {1'b0, dvs};
        diff      = shifted - dvs_ext;
        q_bit     = (shifted >= dvs_ext);
        prem_next = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/mod_div.sv
// rtl/mod_div.sv - 8-bit by 4-bit signed sequential divider, truncating toward zero
//
// Ports:
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   start          - level request, sampled only while idle
//   dividend       - signed 8-bit dividend
//   divisor        - signed 4-bit divisor
//   quotient       - signed 8-bit quotient (registered, held until next done)
//   remainder      - signed 4-bit remainder (registered, held until next done)
//   busy           - operation in progress
//   done           - one-cycle pulse when results update
//   div_zero       - result flag: divisor was zero
//   overflow       - result flag: quotient not representable (-128 / -1)
module mod_div
    import mod_div_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic                  overflow
);

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]      cnt;
    // Holds |dividend| at capture; dividend bits shift out of the top while
    // quotient bits shift in at the bottom.
    logic [DIVIDEND_W-1:0] q_reg;
    logic [PREM_W-1:0]     prem;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic                  q_neg;
    logic                  r_neg;
    logic                  dz_reg;

    logic [PREM_W-1:0]     prem_next;
    logic                  q_bit;
    logic                  divisor_zero;

    assign divisor_zero = (divisor == '0);
    assign busy         = (state != IDLE);

    mod_div_step u_step (
        .prem      (prem),
        .bit_in    (q_reg[DIVIDEND_W-1]),
        .dvs       (dvs_mag),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // A zero divisor skips the iterations entirely.
                    next_state = divisor_zero ? FINISH : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            q_reg     <= '0;
            prem      <= '0;
            dvs_mag   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz_reg    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= CNT_W'(ITER_N - 1);
                        q_reg   <= abs_dividend(dividend);
                        dvs_mag <= abs_divisor(divisor);
                        q_neg   <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                        r_neg   <= dividend[DIVIDEND_W-1];
                        dz_reg  <= divisor_zero;
                        // On divide-by-zero the raw low nibble is the reported remainder.
                        prem    <= divisor_zero ? {1'b0, dividend[DIVISOR_W-1:0]} : '0;
                    end
                end
                CALC: begin
                    prem  <= prem_next;
                    q_reg <= {q_reg[DIVIDEND_W-2:0], q_bit};
                    cnt   <= cnt - 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                    if (dz_reg) begin
                        quotient  <= '1;
                        remainder <= prem[DIVISOR_W-1:0];
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                    end else begin
                        quotient  <= q_neg ? (~q_reg + 1'b1) : q_reg;
                        remainder <= r_neg ? (~prem[DIVISOR_W-1:0] + 1'b1) : prem[DIVISOR_W-1:0];
                        div_zero  <= 1'b0;
                        // Magnitude 128 is only legal when the result is negative.
                        overflow  <= q_reg[DIVIDEND_W-1] & ~q_neg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_div.sv
// tb/tb_mod_div.sv - self-checking testbench for mod_div
module tb_mod_div;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;
    logic       overflow;

    int checks;
    int errors;

    // observations from the most recent run_op
    int         obs_lat;
    logic       obs_busy;
    logic       obs_busy_end;
    logic       obs_done_next;
    logic [7:0] obs_q;
    logic [3:0] obs_r;
    logic       obs_dz;
    logic       obs_ov;

    mod_div dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: integer division truncating toward zero.
    function automatic void model(input logic [7:0] a8, input logic [3:0] b4,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic dz, output logic ov, output int lat);
        int a;
        int b;
        int qi;
        int ri;
        a = int'($signed(a8));
        b = int'($signed(b4));
        if (b == 0) begin
            q = 8'hFF; r = a8[3:0]; dz = 1'b1; ov = 1'b0; lat = 1;
        end else begin
            qi = a / b;
            ri = a % b;
            q = qi[7:0]; r = ri[3:0]; dz = 1'b0; ov = (qi > 127); lat = 9;
        end
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        obs_busy = busy;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        obs_lat  = 0;
        do begin
            @(posedge clock);
            #1;
            obs_lat++;
        end while (!done && obs_lat < 20);
        obs_q        = quotient;
        obs_r        = remainder;
        obs_dz       = div_zero;
        obs_ov       = overflow;
        obs_busy_end = busy;
        @(posedge clock);
        #1;
        obs_done_next = done;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_zero, overflow} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b ov=%b expected all 0",
                     busy, done, quotient, remainder, div_zero, overflow);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'd100, 8'h9C, 8'd100, 8'd5, 8'h80, 8'd6};
        logic [3:0] tb [6] = '{4'd7,   4'd7,  4'h8,   4'd0, 4'hF,  4'd3};
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;
        logic       eov;
        int         elat;
        for (int i = 0; i < 6; i++) begin
            model(ta[i], tb[i], eq, er, edz, eov, elat);
            run_op(ta[i], tb[i]);
            checks++;
            if (obs_lat !== elat || obs_busy !== 1'b1 || obs_busy_end !== 1'b0 || obs_done_next !== 1'b0) begin
                errors++;
                $display("FAIL directed_timing %0d/%0d got lat=%0d busy=%b busy_end=%b done_next=%b expected lat=%0d 1 0 0",
                         $signed(ta[i]), $signed(tb[i]), obs_lat, obs_busy, obs_busy_end, obs_done_next, elat);
            end
            checks++;
            if (obs_q !== eq || obs_r !== er || obs_dz !== edz || obs_ov !== eov) begin
                errors++;
                $display("FAIL directed_result %0d/%0d got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                         $signed(ta[i]), $signed(tb[i]), obs_q, obs_r, obs_dz, obs_ov, eq, er, edz, eov);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;
        logic       eov;
        int         elat;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            model(a, b, eq, er, edz, eov, elat);
            run_op(a, b);
            checks++;
            if (obs_lat !== elat || obs_q !== eq || obs_r !== er || obs_dz !== edz || obs_ov !== eov) begin
                errors++;
                $display("FAIL random %0d/%0d got lat=%0d q=%h r=%h dz=%b ov=%b expected lat=%0d q=%h r=%h dz=%b ov=%b",
                         $signed(a), $signed(b), obs_lat, obs_q, obs_r, obs_dz, obs_ov, elat, eq, er, edz, eov);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        @(negedge clock);
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 4;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!done && n < 20);
        checks++;
        if (n !== 9 || quotient !== 8'h0E || remainder !== 4'h2 || div_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d q=%h r=%h dz=%b ov=%b expected lat=9 q=0e r=2 dz=0 ov=0",
                     n, quotient, remainder, div_zero, overflow);
        end
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_after got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clock);
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clock);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!done && n < 20);
        checks++;
        if (n !== 9 || quotient !== 8'h0E || remainder !== 4'h2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d q=%h r=%h busy=%b expected lat=9 q=0e r=2 busy=0",
                     n, quotient, remainder, busy);
        end
        dividend = 8'h9C;
        divisor  = 4'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart got busy=%b done=%b expected 1 0", busy, done);
        end
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!done && n < 20);
        checks++;
        if (n !== 9 || quotient !== 8'hF2 || remainder !== 4'hE) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d q=%h r=%h expected lat=9 q=f2 r=e", n, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clock);
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_zero, overflow} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h dz=%b ov=%b expected all 0",
                     busy, done, quotient, remainder, div_zero, overflow);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d active cycles expected 0", pulses);
        end
        run_op(8'd6, 4'd3);
        checks++;
        if (obs_lat !== 9 || obs_q !== 8'h02 || obs_r !== 4'h0 || obs_dz !== 1'b0 || obs_ov !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got lat=%0d q=%h r=%h dz=%b ov=%b expected lat=9 q=02 r=0 dz=0 ov=0",
                     obs_lat, obs_q, obs_r, obs_dz, obs_ov);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_div.md
MOD_DIV -- requirements
Module: mod_div

Interface
REQ-001 Parameters SHALL be none; widths are fixed at dividend 8 bits and divisor 4 bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level request; sampled only in IDLE.
REQ-005 dividend  input  8  signed two's-complement dividend.
REQ-006 divisor  input  4  signed two's-complement divisor.
REQ-007 quotient  output  8  signed quotient, registered.
REQ-008 remainder  output  4  signed remainder, registered.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when results update.
REQ-011 div_zero  output  1  result flag: divisor was 0.
REQ-012 overflow  output  1  result flag: quotient not representable.

Function
REQ-013 Division SHALL truncate toward zero: dividend = quotient*divisor + remainder; |remainder| < |divisor|; remainder sign equals dividend sign, or remainder is 0.
REQ-014 FSM states SHALL be IDLE, CALC and FINISH.
REQ-015 IDLE with start=1 at edge k SHALL capture the operand magnitudes and signs, load an iteration counter with 7 and enter CALC; busy is 1 from edge k.
REQ-016 CALC SHALL perform one unsigned restoring shift/subtract step per edge on 8-bit |dividend| by 4-bit |divisor| (5-bit partial remainder), edges k+1..k+8, then enter FINISH.
REQ-017 FINISH at edge k+9 SHALL apply signs, update quotient, remainder and flags, pulse done=1 for one cycle, clear busy and return to IDLE; latency start-to-done is 9 edges.
REQ-018 divisor=0 at capture SHALL bypass CALC: at edge k+1 quotient=8'hFF, remainder=dividend[3:0], div_zero=1, overflow=0, done=1, busy=0.
REQ-019 Dividend -128 with divisor -1 SHALL give quotient=8'h80, remainder=4'h0, overflow=1, div_zero=0, with normal latency.
REQ-020 Flags SHALL be cleared on every non-exceptional result.
REQ-021 start while busy=1 SHALL be ignored; operand changes after capture SHALL not affect the result.
REQ-022 start held high through done SHALL begin a new operation at the edge where the FSM is back in IDLE, so back-to-back operations have one idle cycle between them.
REQ-023 quotient, remainder and flags SHALL hold their last values until the next done.

Reset
REQ-024 reset_n=0 SHALL immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, overflow=0 and counter=0, at any time.
REQ-025 Reset during CALC SHALL abandon the operation with no done pulse; the first start after reset release behaves as from power-up.

Structure
REQ-026 Package mod_div_pkg SHALL hold the state encoding, width constants (8, 4, 5) and iteration count 8.
REQ-027 Sub-module mod_div_step SHALL be combinational: one restoring step producing the next partial remainder and quotient bit; mod_div instantiates it once.

Verification
REQ-028 100 / 7 -> after 9 edges quotient=8'h0E, remainder=4'h2, flags 0, one done pulse.
REQ-029 -100 / 7 -> quotient=8'hF2 (-14), remainder=4'hE (-2); 100 / -8 -> quotient=8'hF4 (-12), remainder=4'h4.
REQ-030 5 / 0 -> at edge k+1 quotient=8'hFF, remainder=4'h5, div_zero=1, done=1.
REQ-031 -128 / -1 -> quotient=8'h80, remainder=0, overflow=1; the following 6 / 3 -> quotient=2, remainder=0, overflow=0.
REQ-032 start pulsed at cycle 4 of CALC with new operands -> ignored, first result unchanged; reset_n=0 at cycle 5 of CALC -> all outputs 0 at once and no done pulse.
